// File: rtl/sext_accumulator.sv
// Purpose : sign-extends a stream of signed bytes and reduces each block of 2^LOG2_N samples to one 32-bit sum (or average when SEXT_ACC_AVG_EN is defined).
// Latency : result registered on the edge that accepts the last sample of a block; out_valid visible the following cycle.
// Backpres: while a result is held, in_ready is low and out_1 stays stable until out_ready; reset (sync, active-high) discards partial and held blocks.
module sext_accumulator #(
   parameter int LOG2_N = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_1,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_1,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  sample_cnt
);

   // Index of the last sample in a block; N is at most 256 so it fits in 8 bits.
   localparam logic [7:0] CNT_LAST = 8'((1 << LOG2_N) - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] acc;
   logic [31:0] acc_nxt;
   logic [7:0]  cnt;
   logic [7:0]  cnt_nxt;
   logic [31:0] res_q;
   logic [31:0] res_nxt;

   logic        in_hs;
   logic        out_hs;
   logic [31:0] sample_sext;
   logic [31:0] block_sum;
   logic [31:0] block_result;

   // Handshake decode: in_ready depends only on state (and reset), never on out_ready.
   always_comb begin
      in_ready  = (state == ACCUM) && !reset;
      out_valid = (state == HOLD);
      in_hs     = in_valid && in_ready;
      out_hs    = out_valid && out_ready;
   end

   // Widen the incoming byte and form the running sum including this sample.
   always_comb begin
      sample_sext = {{24{in_1[7]}}, in_1};
      block_sum   = acc + sample_sext;
`ifdef SEXT_ACC_AVG_EN
      // Arithmetic shift: average rounded toward negative infinity.
      block_result = 32'($signed(block_sum) >>> LOG2_N);
`else
      block_result = block_sum;
`endif
   end

   // Next-state and datapath update; everything holds unless a handshake occurs.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      res_nxt   = res_q;
      case (state)
         ACCUM: begin
            if (in_hs) begin
               if (cnt == CNT_LAST) begin
                  res_nxt   = block_result;
                  acc_nxt   = 32'h0;
                  cnt_nxt   = 8'h0;
                  state_nxt = HOLD;
               end else begin
                  acc_nxt = block_sum;
                  cnt_nxt = cnt + 8'h1;
               end
            end
         end
         HOLD: begin
            if (out_hs) begin
               state_nxt = ACCUM;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   // State and datapath registers; reset drops any partial or unconsumed block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ACCUM;
         acc   <= 32'h0;
         cnt   <= 8'h0;
         res_q <= 32'h0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         res_q <= res_nxt;
      end
   end

   // Registered outputs.
   always_comb begin
      out_1      = res_q;
      sample_cnt = cnt;
   end

endmodule

// File: tb/tb_sext_accumulator.sv
// Purpose : directed self-checking bench for sext_accumulator (LOG2_N=2 and LOG2_N=8 instances).
// Latency : inputs driven on falling edges, outputs sampled on falling edges one cycle later.
// Backpres: exercises held results with out_ready low and reset while holding.
`timescale 1ns/1ps
module tb_sext_accumulator;

   logic        clk;
   logic        reset;
   logic        out_ready;

   logic [7:0]  in_1_a;
   logic        in_valid_a;
   logic        in_ready_a;
   logic [31:0] out_1_a;
   logic        out_valid_a;
   logic [7:0]  sample_cnt_a;

   logic [7:0]  in_1_b;
   logic        in_valid_b;
   logic        in_ready_b;
   logic [31:0] out_1_b;
   logic        out_valid_b;
   logic [7:0]  sample_cnt_b;

   int tests_run;
   int tests_failed;

   sext_accumulator #(.LOG2_N(2)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .in_1       (in_1_a),
      .in_valid   (in_valid_a),
      .in_ready   (in_ready_a),
      .out_1      (out_1_a),
      .out_valid  (out_valid_a),
      .out_ready  (out_ready),
      .sample_cnt (sample_cnt_a)
   );

   sext_accumulator #(.LOG2_N(8)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .in_1       (in_1_b),
      .in_valid   (in_valid_b),
      .in_ready   (in_ready_b),
      .out_1      (out_1_b),
      .out_valid  (out_valid_b),
      .out_ready  (out_ready),
      .sample_cnt (sample_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one sample to dut_a; it is taken on the next rising edge.
   task automatic drive_a(input logic [7:0] v);
      @(negedge clk);
      in_valid_a = 1'b1;
      in_1_a     = v;
   endtask

   task automatic idle_a;
      @(negedge clk);
      in_valid_a = 1'b0;
      in_1_a     = 8'hAA;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (in_ready_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_in_ready_during_reset got %b want 0", in_ready_a);
      end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_1_a !== 32'h0 || sample_cnt_a !== 8'h0) begin
         tests_failed++;
         $display("FAIL reset_values got rdy=%b vld=%b out=%h cnt=%0d want rdy=1 vld=0 out=0 cnt=0",
                  in_ready_a, out_valid_a, out_1_a, sample_cnt_a);
      end
      tests_run++;
      if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || sample_cnt_b !== 8'h0) begin
         tests_failed++;
         $display("FAIL reset_values_n256 got rdy=%b vld=%b cnt=%0d", in_ready_b, out_valid_b, sample_cnt_b);
      end
   endtask

   task automatic test_mixed_signs;
      logic [7:0]  vec [4];
      logic [31:0] exp;
      vec[0] = 8'hFD; vec[1] = 8'h05; vec[2] = 8'hF1; vec[3] = 8'h0F;
`ifdef SEXT_ACC_AVG_EN
      exp = 32'h00000000;
`else
      exp = 32'h00000002;
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) drive_a(vec[i]);
      idle_a();
      tests_run++;
      if (out_valid_a !== 1'b1 || out_1_a !== exp) begin
         tests_failed++;
         $display("FAIL mixed_signs_result got vld=%b out=%h want vld=1 out=%h", out_valid_a, out_1_a, exp);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL mixed_signs_single_pulse got vld=%b rdy=%b want vld=0 rdy=1", out_valid_a, in_ready_a);
      end
   endtask

   task automatic test_most_negative;
      logic [31:0] exp;
`ifdef SEXT_ACC_AVG_EN
      exp = 32'hFFFFFF80;
`else
      exp = 32'hFFFFFE00;
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) drive_a(8'h80);
      idle_a();
      tests_run++;
      if (out_valid_a !== 1'b1 || out_1_a !== exp) begin
         tests_failed++;
         $display("FAIL most_negative got vld=%b out=%h want vld=1 out=%h", out_valid_a, out_1_a, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [31:0] exp;
      int bad;
`ifdef SEXT_ACC_AVG_EN
      exp = 32'h00000002;
`else
      exp = 32'h00000008;
`endif
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_a(8'h02);
      // Keep offering a sample during HOLD; it must not be taken.
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid_a = 1'b1;
         in_1_a     = 8'h55;
         if (out_valid_a !== 1'b1 || out_1_a !== exp || in_ready_a !== 1'b0 || sample_cnt_a !== 8'h0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL backpressure_hold %0d bad cycles, last vld=%b out=%h rdy=%b cnt=%0d want vld=1 out=%h rdy=0 cnt=0",
                  bad, out_valid_a, out_1_a, in_ready_a, sample_cnt_a, exp);
      end
      @(negedge clk);
      in_valid_a = 1'b0;
      out_ready  = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || sample_cnt_a !== 8'h0) begin
         tests_failed++;
         $display("FAIL backpressure_release got vld=%b rdy=%b cnt=%0d want vld=0 rdy=1 cnt=0",
                  out_valid_a, in_ready_a, sample_cnt_a);
      end
   endtask

   task automatic test_gaps;
      logic [31:0] exp;
      int bad;
`ifdef SEXT_ACC_AVG_EN
      exp = 32'h00000001;
`else
      exp = 32'h00000004;
`endif
      out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (sample_cnt_a !== 8'(i)) bad++;
         drive_a(8'h01);
         for (int g = 0; g < 3; g++) idle_a();
         if (i < 3 && sample_cnt_a !== 8'(i + 1)) bad++;
      end
      tests_run++;
      if (bad != 0 || sample_cnt_a !== 8'h0) begin
         tests_failed++;
         $display("FAIL gaps_count_sequence %0d bad steps, final cnt=%0d want 0", bad, sample_cnt_a);
      end
      tests_run++;
      if (out_1_a !== exp) begin
         tests_failed++;
         $display("FAIL gaps_result got %h want %h", out_1_a, exp);
      end
   endtask

   task automatic test_reset_mid_block;
      logic [31:0] exp;
`ifdef SEXT_ACC_AVG_EN
      exp = 32'h00000001;
`else
      exp = 32'h00000004;
`endif
      out_ready = 1'b1;
      drive_a(8'h7F);
      drive_a(8'h7F);
      // Reset with a sample offered: reset wins.
      @(negedge clk);
      reset      = 1'b1;
      in_valid_a = 1'b1;
      in_1_a     = 8'h7F;
      @(negedge clk);
      reset      = 1'b0;
      in_valid_a = 1'b0;
      tests_run++;
      if (sample_cnt_a !== 8'h0 || out_valid_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_block_cnt got cnt=%0d vld=%b want 0 0", sample_cnt_a, out_valid_a);
      end
      for (int i = 0; i < 4; i++) drive_a(8'h01);
      idle_a();
      tests_run++;
      if (out_valid_a !== 1'b1 || out_1_a !== exp) begin
         tests_failed++;
         $display("FAIL reset_mid_block_result got vld=%b out=%h want vld=1 out=%h", out_valid_a, out_1_a, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_in_hold;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_a(8'h10);
      idle_a();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid_a !== 1'b0 || out_1_a !== 32'h0 || in_ready_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_hold got vld=%b out=%h rdy=%b want vld=0 out=0 rdy=1",
                  out_valid_a, out_1_a, in_ready_a);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back;
      int pulses;
      int first_at;
      out_ready  = 1'b1;
      pulses     = 0;
      first_at   = -1;
      @(negedge clk);
      in_valid_a = 1'b1;
      in_1_a     = 8'h03;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (out_valid_a === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = c;
         end
         if (c == 10) in_valid_a = 1'b0;
      end
      tests_run++;
      if (pulses != 2 || first_at != 4) begin
         tests_failed++;
         $display("FAIL back_to_back got pulses=%0d first=%0d want pulses=2 first=4", pulses, first_at);
      end
      tests_run++;
      if (sample_cnt_a !== 8'h0 || in_ready_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL back_to_back_end got cnt=%0d rdy=%b want 0 1", sample_cnt_a, in_ready_a);
      end
   endtask

   task automatic test_n256;
      logic [31:0] exp;
`ifdef SEXT_ACC_AVG_EN
      exp = 32'h0000007F;
`else
      exp = 32'h00007F00;
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         in_valid_b = 1'b1;
         in_1_b     = 8'h7F;
      end
      @(negedge clk);
      tests_run++;
      if (sample_cnt_b !== 8'd255 || out_valid_b !== 1'b0) begin
         tests_failed++;
         $display("FAIL n256_last_count got cnt=%0d vld=%b want 255 0", sample_cnt_b, out_valid_b);
      end
      @(negedge clk);
      in_valid_b = 1'b0;
      tests_run++;
      if (out_valid_b !== 1'b1 || out_1_b !== exp || sample_cnt_b !== 8'h0) begin
         tests_failed++;
         $display("FAIL n256_result got vld=%b out=%h cnt=%0d want vld=1 out=%h cnt=0",
                  out_valid_b, out_1_b, sample_cnt_b, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      out_ready    = 1'b1;
      in_valid_a   = 1'b0;
      in_1_a       = 8'h00;
      in_valid_b   = 1'b0;
      in_1_b       = 8'h00;

      test_reset();
      test_mixed_signs();
      test_most_negative();
      test_backpressure();
      test_gaps();
      test_reset_mid_block();
      test_reset_in_hold();
      test_back_to_back();
      test_n256();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sext_accumulator.md
# sext_accumulator

Downstream consumer of the 8-bit to 32-bit sign-extension stage. It accepts a stream of signed bytes over a valid/ready handshake and sign-extends each byte to 32 bits internally. It accumulates blocks of N = 2^LOG2_N samples and presents each block's 32-bit sum (or average, see Configuration) on a held valid/ready output. It turns the combinational widening step into a sequential, flow-controlled reduction stage.

## Interface
- LOG2_N, default 2: log2 of samples per block; legal range 1..8, so N ranges 2..256.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_1  input  8  signed two's-complement sample.
- in_valid  input  1  in_1 is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- out_1  output  32  block result, sign-extended two's complement.
- out_valid  output  1  out_1 holds a completed block result.
- out_ready  input  1  downstream accepts out_1 this cycle.
- sample_cnt  output  8  samples accepted in the current block, 0..N-1.

## Operation
- Two-state FSM.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input handshake = in_valid & in_ready, sampled on the rising clk edge.
- Sign extension: each accepted sample becomes {{24{in_1[7]}}, in_1} before it is added.
- Accumulator: 32-bit register acc.
  - Worst-case |sum| is 128*256 = 32768, so the sum cannot overflow. No saturation logic.
- ACCUM, handshake with sample_cnt < N-1: acc <= acc + sext(in_1); sample_cnt increments.
- ACCUM, handshake with sample_cnt == N-1:
  - out_1 <= result(acc + sext(in_1)).
  - acc <= 0, sample_cnt <= 0.
  - State moves to HOLD.
- ACCUM with no handshake: all registers hold their values.
- HOLD: out_1 and out_valid stay stable until out_ready=1.
  - On out_valid & out_ready, state returns to ACCUM on the next cycle.
- in_ready is a pure decode of the state, with no combinational path from out_ready. A sample cannot be accepted in the same cycle the result is consumed.
- reset from any state:
  - state <= ACCUM; acc, sample_cnt and out_1 <= 0.
  - Any partial block is discarded.
  - A HOLD result not yet consumed is dropped.

## Timing
- Reset values: in_ready=1 (after the reset cycle), out_valid=0, out_1=32'h0, sample_cnt=0.
- While reset is asserted, in_ready=0 and no handshake occurs.
- Latency: out_valid rises on the clock edge that accepts the Nth sample, so it is visible in the following cycle.
- Maximum throughput: one block per N+1 cycles (N accept cycles plus one HOLD cycle with out_ready tied high).
- Gaps (in_valid=0) are allowed anywhere within a block and do not affect the result.
- Values of in_1 are ignored when no handshake occurs.
- Backpressure: HOLD may last indefinitely. out_1 must not change while out_valid=1 and out_ready=0.
- Reset asserted together with a handshake: reset wins and the sample is not counted.

## Configuration
- Macro SEXT_ACC_AVG_EN.
- Defined: out_1 = (acc + sext(in_1)) >>> LOG2_N, an arithmetic shift that gives the block average rounded toward negative infinity.
- Undefined: out_1 = the full block sum, unshifted.
- The FSM, handshake and timing are identical in both builds.

## Test plan
- LOG2_N=2, continuous in_valid, out_ready=1, samples 8'hFD, 8'h05, 8'hF1, 8'h0F:
  - Sum build: out_1=32'h00000002.
  - Avg build: out_1=32'h00000000.
  - out_valid high for exactly 1 cycle.
- LOG2_N=2, four samples of 8'h80:
  - Sum build: out_1=32'hFFFFFE00.
  - Avg build: out_1=32'hFFFFFF80.
- Backpressure: after a block completes, hold out_ready=0 for 5 cycles.
  - out_1 and out_valid stay stable; in_ready=0 throughout.
  - Raising out_ready gives exactly one transfer, and in_ready returns to 1 the next cycle.
- Gaps: four samples of 8'h01 with in_valid low for 3 cycles between each.
  - out_1=32'h00000004 (sum build); sample_cnt steps 0,1,2,3,0.
- Reset mid-block: after two samples of 8'h7F, assert reset for 1 cycle, then send four samples of 8'h01.
  - out_1=32'h00000004; sample_cnt=0 right after reset.
- LOG2_N=8: 256 samples of 8'h7F.
  - Sum build: out_1=32'h00007F00.
  - Avg build: out_1=32'h0000007F.
